pipeline_skid_reg: RTL and testbench
====================================

Name: pipeline_skid_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the RV32IM pipeline.
- Successor to the fixed-field stage registers: the stage's fields are packed into one DATA_WIDTH bus.
- Adds a valid/ready handshake, a 2-entry skid buffer, synchronous flush and a stall-cycle counter. The global BUSYWAIT freeze is retained.
- Sits between any two stages (IF/ID … MEM/WB) so that back-pressure from one stage does not drop in-flight instructions.

Parameters:
- DATA_WIDTH, 136, width of the packed payload (MEM/WB default: 5+4*32+2+1).
- RESET_VALUE, {DATA_WIDTH{1'b0}}, value loaded into OUT_DATA on reset and flush (callers encode e.g. PC_4 = -4 here).
- CNT_WIDTH, 16, width of STALL_COUNT.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- BUSYWAIT  in  1  global memory stall; freezes all state.
- FLUSH  in  1  synchronous squash of the stage contents.
- IN_VALID  in  1  upstream payload valid.
- IN_READY  out  1  stage can accept a payload this cycle.
- IN_DATA  in  DATA_WIDTH  upstream payload.
- OUT_VALID  out  1  OUT_DATA holds a live payload.
- OUT_READY  in  1  downstream accepts the payload.
- OUT_DATA  out  DATA_WIDTH  registered payload to the next stage.
- STALL_COUNT  out  CNT_WIDTH  saturating count of stalled cycles.

Behaviour:
- Storage:
  - main register (drives OUT_DATA, main_v = OUT_VALID).
  - skid register (skid_d, skid_v).
- States, derived from the valid bits: EMPTY (main_v=0), ONE (main_v=1, skid_v=0), TWO (both valid). skid_v=1 with main_v=0 is illegal and must never occur.
- Handshake signals:
  - IN_READY = !skid_v && !BUSYWAIT (combinational from BUSYWAIT only).
  - acc = IN_VALID && IN_READY.
  - dep = OUT_VALID && OUT_READY && !BUSYWAIT.
- Transitions, when FLUSH=0 and BUSYWAIT=0:
  - EMPTY: acc -> ONE, main <= IN_DATA.
  - ONE: acc&dep -> ONE, main <= IN_DATA. acc&!dep -> TWO, skid <= IN_DATA. !acc&dep -> EMPTY. Otherwise hold.
  - TWO: IN_READY=0. dep -> ONE, main <= skid_d, skid_v <= 0. Otherwise hold.
- Latency: a payload accepted at edge N is visible on OUT_DATA/OUT_VALID after edge N (1 cycle). Ordering is strictly FIFO; no payload is dropped or duplicated.
- BUSYWAIT=1:
  - No register changes, including data, valids and state.
  - OUT_DATA and OUT_VALID hold their values.
  - The only exception is STALL_COUNT, below.
- FLUSH=1 at an edge:
  - main_v, skid_v <= 0 and main data <= RESET_VALUE.
  - Any payload offered that cycle is discarded.
  - FLUSH has priority over BUSYWAIT and over acc/dep.
- EMPTY: OUT_DATA holds its last value (not cleared) except after reset or flush; downstream must qualify it with OUT_VALID.
- STALL_COUNT:
  - Increments by 1 on each edge where BUSYWAIT=1, or OUT_VALID=1 && OUT_READY=0.
  - Saturates at all-ones.
  - Unaffected by FLUSH; cleared only by reset.
- RESET=0 (asynchronous, any time, including mid-transfer):
  - Immediately OUT_VALID=0, skid_v=0, OUT_DATA=RESET_VALUE, skid_d=0, STALL_COUNT=0.
  - IN_READY=!BUSYWAIT while RESET is asserted.
  - First possible acceptance is the first rising edge after RESET deasserts.

Decomposition:
- Shared constants file:
  - per-stage packed widths (IF_ID_W, ID_EX_W, EX_MEM_W, MEM_WB_W).
  - field offset macros for packing/unpacking.
  - per-stage RESET_VALUE constants (e.g. PC_4 = 32'hFFFFFFFC).
- One natural sub-module: pipeline_skid_ctrl. It holds the main_v/skid_v state, IN_READY/acc/dep decode and the mux-select/load enables. The datapath registers and the counter stay in the top.

Test Plan (bench DATA_WIDTH=32, RESET_VALUE=32'hFFFFFFFC, CNT_WIDTH=4, CLK period 8):
- Reset: drive RESET=0 mid-cycle with IN_VALID=1, IN_DATA=23 -> immediately OUT_VALID=0, OUT_DATA=FFFFFFFC, STALL_COUNT=0. After release, IN_READY=1.
- Streaming: IN_VALID=1, OUT_READY=1, IN_DATA 10,11,12 on consecutive edges -> OUT_DATA 10,11,12 one cycle later each. IN_READY stays 1 and STALL_COUNT stays 0.
- Back-pressure/skid: OUT_READY=0 while offering 45 then 56 -> OUT_DATA=45, IN_READY=0 after the second edge, and 56 is not lost. OUT_READY=1 gives 45 then 56 in order, then OUT_VALID=0.
- BUSYWAIT: with OUT_DATA=15, OUT_VALID=1, raise BUSYWAIT for 3 edges while offering 10 with OUT_READY=1 -> OUT_DATA stays 15, IN_READY=0, STALL_COUNT increments by 3.
- Flush priority: in state TWO (main=1, skid=2), assert FLUSH and BUSYWAIT together while offering 3 -> after the edge OUT_VALID=0, OUT_DATA=FFFFFFFC, skid empty, and 3 is discarded.
- Counter saturation: hold OUT_VALID=1, OUT_READY=0 for 20 edges -> STALL_COUNT=4'hF and stays there. It returns to 0 only on reset.

Source files
------------

// File: rtl/pipeline_skid_reg_pkg.sv
// Shared stage-register constants: packed widths, field offsets and reset payloads
// for the RV32IM inter-stage registers built on pipeline_skid_reg.
package pipeline_skid_reg_pkg;

  localparam int unsigned XLEN = 32;

  localparam int unsigned IF_ID_W  = 3 * XLEN;                  // INSTR, PC, PC_4
  localparam int unsigned ID_EX_W  = 5 + 5 + 5 + 4 * XLEN + 16;  // rd/rs1/rs2, 4 data words, control
  localparam int unsigned EX_MEM_W = 5 + 3 * XLEN + 8;           // rd, ALU/store/PC_4, control
  localparam int unsigned MEM_WB_W = 5 + 4 * XLEN + 2 + 1;       // rd, 4 data words, WB_SEL, REG_WRITE

  // MEM/WB field offsets, LSB first
  localparam int unsigned MEM_WB_REG_WRITE_O = 0;
  localparam int unsigned MEM_WB_WB_SEL_O    = 1;
  localparam int unsigned MEM_WB_ALU_O       = 3;
  localparam int unsigned MEM_WB_MEM_O       = MEM_WB_ALU_O + XLEN;
  localparam int unsigned MEM_WB_PC_4_O      = MEM_WB_MEM_O + XLEN;
  localparam int unsigned MEM_WB_IMM_O       = MEM_WB_PC_4_O + XLEN;
  localparam int unsigned MEM_WB_RD_O        = MEM_WB_IMM_O + XLEN;

  // IF/ID field offsets, LSB first
  localparam int unsigned IF_ID_PC_4_O  = 0;
  localparam int unsigned IF_ID_PC_O    = XLEN;
  localparam int unsigned IF_ID_INSTR_O = 2 * XLEN;

  localparam logic [XLEN-1:0] PC_4_RESET = 32'hFFFF_FFFC;

  localparam logic [IF_ID_W-1:0]  IF_ID_RESET  = {{(IF_ID_W - XLEN){1'b0}}, PC_4_RESET};
  localparam logic [MEM_WB_W-1:0] MEM_WB_RESET =
    {{(MEM_WB_W - MEM_WB_PC_4_O - XLEN){1'b0}}, PC_4_RESET, {MEM_WB_PC_4_O{1'b0}}};

  function automatic logic [MEM_WB_W-1:0] mem_wb_pack(
    input logic [4:0]      rd,
    input logic [XLEN-1:0] imm,
    input logic [XLEN-1:0] pc_4,
    input logic [XLEN-1:0] mem_data,
    input logic [XLEN-1:0] alu,
    input logic [1:0]      wb_sel,
    input logic            reg_write
  );
    return {rd, imm, pc_4, mem_data, alu, wb_sel, reg_write};
  endfunction

endpackage

// File: rtl/pipeline_skid_ctrl.sv
// Occupancy control for the skid register: main/skid valid bits, handshake decode
// and the load enables / mux select for the datapath in the top.
module pipeline_skid_ctrl
  import pipeline_skid_reg_pkg::*;
(
  input  logic CLK,
  input  logic RESET,
  input  logic BUSYWAIT,
  input  logic FLUSH,
  input  logic IN_VALID,
  input  logic OUT_READY,
  output logic IN_READY,
  output logic main_v,
  output logic skid_v,
  output logic load_main,
  output logic main_from_skid,
  output logic load_skid
);

  logic acc;
  logic dep;
  logic main_v_nxt;
  logic skid_v_nxt;

  assign IN_READY = !skid_v && !BUSYWAIT;
  assign acc      = IN_VALID && IN_READY;
  assign dep      = main_v && OUT_READY && !BUSYWAIT;

  // acc and dep both fold in BUSYWAIT, so a freeze falls through every branch as a hold
  always_comb begin
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    main_v_nxt     = main_v;
    skid_v_nxt     = skid_v;
    if (skid_v) begin
      if (dep) begin
        load_main      = 1'b1;
        main_from_skid = 1'b1;
        skid_v_nxt     = 1'b0;
      end
    end else if (main_v) begin
      if (acc && dep) begin
        load_main = 1'b1;
      end else if (acc) begin
        load_skid  = 1'b1;
        skid_v_nxt = 1'b1;
      end else if (dep) begin
        main_v_nxt = 1'b0;
      end
    end else if (acc) begin
      load_main  = 1'b1;
      main_v_nxt = 1'b1;
    end
    if (FLUSH) begin
      load_main      = 1'b0;
      main_from_skid = 1'b0;
      load_skid      = 1'b0;
      main_v_nxt     = 1'b0;
      skid_v_nxt     = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else begin
      main_v <= main_v_nxt;
      skid_v <= skid_v_nxt;
    end
  end

endmodule

// File: rtl/pipeline_skid_reg.sv
// Parametrised inter-stage pipeline register with valid/ready handshake, 2-entry skid
// buffer, synchronous flush, BUSYWAIT freeze and a saturating stall-cycle counter.
module pipeline_skid_reg
  import pipeline_skid_reg_pkg::*;
#(
  parameter int unsigned                  DATA_WIDTH  = MEM_WB_W,
  parameter logic [DATA_WIDTH-1:0]        RESET_VALUE = '0,
  parameter int unsigned                  CNT_WIDTH   = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  BUSYWAIT,
  input  logic                  FLUSH,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic [CNT_WIDTH-1:0]  STALL_COUNT
);

  logic                  main_v;
  logic                  skid_v;
  logic                  load_main;
  logic                  main_from_skid;
  logic                  load_skid;
  logic [DATA_WIDTH-1:0] skid_d;

  pipeline_skid_ctrl u_ctrl (
    .CLK            (CLK),
    .RESET          (RESET),
    .BUSYWAIT       (BUSYWAIT),
    .FLUSH          (FLUSH),
    .IN_VALID       (IN_VALID),
    .OUT_READY      (OUT_READY),
    .IN_READY       (IN_READY),
    .main_v         (main_v),
    .skid_v         (skid_v),
    .load_main      (load_main),
    .main_from_skid (main_from_skid),
    .load_skid      (load_skid)
  );

  assign OUT_VALID = main_v;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      OUT_DATA <= RESET_VALUE;
    end else if (FLUSH) begin
      OUT_DATA <= RESET_VALUE;
    end else if (load_main) begin
      OUT_DATA <= main_from_skid ? skid_d : IN_DATA;
    end
  end

  // skid data is not cleared on flush; skid_v already marks it dead
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      skid_d <= '0;
    end else if (load_skid) begin
      skid_d <= IN_DATA;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      STALL_COUNT <= '0;
    end else if ((BUSYWAIT || (main_v && !OUT_READY)) && (STALL_COUNT != '1)) begin
      STALL_COUNT <= STALL_COUNT + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_skid_reg.sv
// Directed self-checking bench for pipeline_skid_reg (32-bit payload, 4-bit counter).
module tb_pipeline_skid_reg;

  localparam logic [31:0] RV = 32'hFFFF_FFFC;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        BUSYWAIT;
  logic        FLUSH;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] IN_DATA;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_DATA;
  logic [3:0]  STALL_COUNT;

  int vecs = 0;
  int errs = 0;

  pipeline_skid_reg #(
    .DATA_WIDTH  (32),
    .RESET_VALUE (32'hFFFF_FFFC),
    .CNT_WIDTH   (4)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .BUSYWAIT    (BUSYWAIT),
    .FLUSH       (FLUSH),
    .IN_VALID    (IN_VALID),
    .IN_READY    (IN_READY),
    .IN_DATA     (IN_DATA),
    .OUT_VALID   (OUT_VALID),
    .OUT_READY   (OUT_READY),
    .OUT_DATA    (OUT_DATA),
    .STALL_COUNT (STALL_COUNT)
  );

  always #4 CLK = ~CLK;

  // one rising edge, then settle 1 time unit past it
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    BUSYWAIT = 1'b0; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0; IN_DATA = '0;
    RESET = 1'b0;
    #1;
    RESET = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    vecs++; if (OUT_VALID !== 1'b0) begin errs++; $display("FAIL rst_init_valid got=%b exp=0", OUT_VALID); end
    vecs++; if (OUT_DATA !== RV) begin errs++; $display("FAIL rst_init_data got=%h exp=%h", OUT_DATA, RV); end
    // load some state and bump the counter
    IN_VALID = 1'b1; IN_DATA = 32'd7; OUT_READY = 1'b0;
    step();
    IN_VALID = 1'b0;
    step();
    vecs++; if (STALL_COUNT !== 4'd1) begin errs++; $display("FAIL rst_pre_cnt got=%0d exp=1", STALL_COUNT); end
    // asynchronous assertion mid-cycle with a payload on offer
    #1;
    IN_VALID = 1'b1; IN_DATA = 32'd23;
    RESET = 1'b0;
    #1;
    vecs++; if (OUT_VALID !== 1'b0) begin errs++; $display("FAIL rst_async_valid got=%b exp=0", OUT_VALID); end
    vecs++; if (OUT_DATA !== RV) begin errs++; $display("FAIL rst_async_data got=%h exp=%h", OUT_DATA, RV); end
    vecs++; if (STALL_COUNT !== 4'd0) begin errs++; $display("FAIL rst_async_cnt got=%0d exp=0", STALL_COUNT); end
    vecs++; if (IN_READY !== 1'b1) begin errs++; $display("FAIL rst_in_ready got=%b exp=1", IN_READY); end
    step();
    vecs++; if (OUT_VALID !== 1'b0) begin errs++; $display("FAIL rst_held_valid got=%b exp=0", OUT_VALID); end
    #1;
    RESET = 1'b1;
    #1;
    vecs++; if (IN_READY !== 1'b1) begin errs++; $display("FAIL rst_release_ready got=%b exp=1", IN_READY); end
    step();
    vecs++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 32'd23) begin
      errs++; $display("FAIL rst_first_accept got=%b/%h exp=1/%h", OUT_VALID, OUT_DATA, 32'd23);
    end
  endtask

  task automatic test_streaming();
    logic [31:0] vals [3] = '{32'd10, 32'd11, 32'd12};
    do_reset();
    OUT_READY = 1'b1; IN_VALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      IN_DATA = vals[i];
      step();
      vecs++; if (OUT_VALID !== 1'b1 || OUT_DATA !== vals[i]) begin
        errs++; $display("FAIL stream_data[%0d] got=%b/%h exp=1/%h", i, OUT_VALID, OUT_DATA, vals[i]);
      end
      vecs++; if (IN_READY !== 1'b1) begin errs++; $display("FAIL stream_ready[%0d] got=%b exp=1", i, IN_READY); end
    end
    IN_VALID = 1'b0;
    step();
    vecs++; if (OUT_VALID !== 1'b0 || OUT_DATA !== 32'd12) begin
      errs++; $display("FAIL stream_drain got=%b/%h exp=0/%h", OUT_VALID, OUT_DATA, 32'd12);
    end
    vecs++; if (STALL_COUNT !== 4'd0) begin errs++; $display("FAIL stream_cnt got=%0d exp=0", STALL_COUNT); end
  endtask

  task automatic test_skid();
    do_reset();
    OUT_READY = 1'b0; IN_VALID = 1'b1; IN_DATA = 32'd45;
    step();
    vecs++; if (OUT_DATA !== 32'd45 || IN_READY !== 1'b1) begin
      errs++; $display("FAIL skid_first got=%h/%b exp=%h/1", OUT_DATA, IN_READY, 32'd45);
    end
    IN_DATA = 32'd56;
    step();
    vecs++; if (OUT_DATA !== 32'd45 || OUT_VALID !== 1'b1) begin
      errs++; $display("FAIL skid_hold got=%h/%b exp=%h/1", OUT_DATA, OUT_VALID, 32'd45);
    end
    vecs++; if (IN_READY !== 1'b0) begin errs++; $display("FAIL skid_full_ready got=%b exp=0", IN_READY); end
    // offered while full, must not be taken
    IN_DATA = 32'd67;
    step();
    vecs++; if (OUT_DATA !== 32'd45 || IN_READY !== 1'b0) begin
      errs++; $display("FAIL skid_stall got=%h/%b exp=%h/0", OUT_DATA, IN_READY, 32'd45);
    end
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    step();
    vecs++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 32'd56) begin
      errs++; $display("FAIL skid_second got=%b/%h exp=1/%h", OUT_VALID, OUT_DATA, 32'd56);
    end
    vecs++; if (IN_READY !== 1'b1) begin errs++; $display("FAIL skid_ready_back got=%b exp=1", IN_READY); end
    step();
    vecs++; if (OUT_VALID !== 1'b0) begin errs++; $display("FAIL skid_empty got=%b exp=0", OUT_VALID); end
    vecs++; if (STALL_COUNT !== 4'd2) begin errs++; $display("FAIL skid_cnt got=%0d exp=2", STALL_COUNT); end
  endtask

  task automatic test_busywait();
    do_reset();
    OUT_READY = 1'b1; IN_VALID = 1'b1; IN_DATA = 32'd15;
    step();
    vecs++; if (OUT_DATA !== 32'd15 || OUT_VALID !== 1'b1) begin
      errs++; $display("FAIL bw_setup got=%h/%b exp=%h/1", OUT_DATA, OUT_VALID, 32'd15);
    end
    BUSYWAIT = 1'b1; IN_DATA = 32'd10;
    #1;
    vecs++; if (IN_READY !== 1'b0) begin errs++; $display("FAIL bw_in_ready got=%b exp=0", IN_READY); end
    for (int i = 0; i < 3; i++) begin
      step();
      vecs++; if (OUT_DATA !== 32'd15 || OUT_VALID !== 1'b1) begin
        errs++; $display("FAIL bw_freeze[%0d] got=%h/%b exp=%h/1", i, OUT_DATA, OUT_VALID, 32'd15);
      end
    end
    vecs++; if (STALL_COUNT !== 4'd3) begin errs++; $display("FAIL bw_cnt got=%0d exp=3", STALL_COUNT); end
    BUSYWAIT = 1'b0; IN_VALID = 1'b0;
    step();
    vecs++; if (OUT_VALID !== 1'b0 || OUT_DATA !== 32'd15) begin
      errs++; $display("FAIL bw_release got=%b/%h exp=0/%h", OUT_VALID, OUT_DATA, 32'd15);
    end
    vecs++; if (STALL_COUNT !== 4'd3) begin errs++; $display("FAIL bw_cnt_after got=%0d exp=3", STALL_COUNT); end
  endtask

  task automatic test_flush();
    do_reset();
    OUT_READY = 1'b0; IN_VALID = 1'b1; IN_DATA = 32'd1;
    step();
    IN_DATA = 32'd2;
    step();
    vecs++; if (IN_READY !== 1'b0 || OUT_DATA !== 32'd1) begin
      errs++; $display("FAIL flush_two got=%b/%h exp=0/%h", IN_READY, OUT_DATA, 32'd1);
    end
    FLUSH = 1'b1; BUSYWAIT = 1'b1; IN_DATA = 32'd3;
    step();
    vecs++; if (OUT_VALID !== 1'b0 || OUT_DATA !== RV) begin
      errs++; $display("FAIL flush_clear got=%b/%h exp=0/%h", OUT_VALID, OUT_DATA, RV);
    end
    vecs++; if (STALL_COUNT !== 4'd2) begin errs++; $display("FAIL flush_cnt got=%0d exp=2", STALL_COUNT); end
    FLUSH = 1'b0; BUSYWAIT = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
    #1;
    vecs++; if (IN_READY !== 1'b1) begin errs++; $display("FAIL flush_skid_empty got=%b exp=1", IN_READY); end
    step();
    vecs++; if (OUT_VALID !== 1'b0 || OUT_DATA !== RV) begin
      errs++; $display("FAIL flush_discard got=%b/%h exp=0/%h", OUT_VALID, OUT_DATA, RV);
    end
  endtask

  task automatic test_saturation();
    logic [3:0] exp_cnt;
    do_reset();
    OUT_READY = 1'b0; IN_VALID = 1'b1; IN_DATA = 32'd5;
    step();
    IN_VALID = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      exp_cnt = (i + 1 > 15) ? 4'hF : 4'(i + 1);
      vecs++; if (STALL_COUNT !== exp_cnt || OUT_VALID !== 1'b1) begin
        errs++; $display("FAIL sat_cnt[%0d] got=%0d/%b exp=%0d/1", i, STALL_COUNT, OUT_VALID, exp_cnt);
      end
    end
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    vecs++; if (STALL_COUNT !== 4'hF || OUT_VALID !== 1'b0) begin
      errs++; $display("FAIL sat_flush got=%0d/%b exp=15/0", STALL_COUNT, OUT_VALID);
    end
    step();
    vecs++; if (STALL_COUNT !== 4'hF) begin errs++; $display("FAIL sat_hold got=%0d exp=15", STALL_COUNT); end
    do_reset();
    vecs++; if (STALL_COUNT !== 4'd0) begin errs++; $display("FAIL sat_reset got=%0d exp=0", STALL_COUNT); end
  endtask

  initial begin
    RESET = 1'b0; BUSYWAIT = 1'b0; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0; IN_DATA = '0;
    step();
    test_reset();
    test_streaming();
    test_skid();
    test_busywait();
    test_flush();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
